// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-stage load/store controller.
//   - RV32I funct3 encodings for load/store size and sign
//   - controller state encoding
//   - default REQ timeout, in cycles
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_fmt.sv
// lsu_fmt: purely combinational access formatter.
// Ports:
//   i_is_store  1 = store access, 0 = load access
//   i_funct3    RV32I size/sign encoding
//   i_addr_lo   byte offset within the word
//   i_wdata     right-aligned store data
//   i_rdata     raw word returned by memory
//   o_ok        funct3 legal for this direction and address aligned
//   o_wstrb     byte-lane strobes (0 for loads)
//   o_wdata     lane-replicated store data (0 for loads)
//   o_rdata     extracted and extended load data (0 for stores)
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_ok,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes of the returned word.
  always_comb begin
    w_byte = 8'd0;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Legality/alignment check, store strobes and replication, load extension.
  always_comb begin
    o_ok    = 1'b0;
    o_wstrb = 4'b0000;
    o_wdata = 32'd0;
    o_rdata = 32'd0;
    case (i_funct3)
      F3_B: begin
        o_ok = 1'b1;
        if (i_is_store) begin
          o_wstrb = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end else begin
          o_rdata = {{24{w_byte[7]}}, w_byte};
        end
      end
      F3_H: begin
        o_ok = ~i_addr_lo[0];
        if (i_is_store) begin
          o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_wdata = {2{i_wdata[15:0]}};
        end else begin
          o_rdata = {{16{w_half[15]}}, w_half};
        end
      end
      F3_W: begin
        o_ok = (i_addr_lo == 2'b00);
        if (i_is_store) begin
          o_wstrb = 4'b1111;
          o_wdata = i_wdata;
        end else begin
          o_rdata = i_rdata;
        end
      end
      F3_BU: begin
        // Unsigned variants exist only for loads.
        if (i_is_store) begin
          o_ok = 1'b0;
        end else begin
          o_ok    = 1'b1;
          o_rdata = {24'd0, w_byte};
        end
      end
      F3_HU: begin
        if (i_is_store) begin
          o_ok = 1'b0;
        end else begin
          o_ok    = ~i_addr_lo[0];
          o_rdata = {16'd0, w_half};
        end
      end
      default: begin
        o_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: memory-stage load/store controller.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rd_enMW, wr_enMW    load/store request of the instruction in MW (store wins)
//   funct3MW, addrMW    access size/sign and byte address
//   wdataMW             right-aligned store data
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_wstrb   request to data memory
//   mem_ready, mem_rdata                              response from data memory
//   rdata_out           formatted load data, valid in DONE
//   lsu_stall           holds PC and pipeline buffers while an access is pending
//   misalign_err        one-cycle pulse for misaligned / illegal-funct3 access
//   bus_err             one-cycle pulse in DONE when the access timed out
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_enMW,
  input  logic              wr_enMW,
  input  logic [2:0]        funct3MW,
  input  logic [ADDR_W-1:0] addrMW,
  input  logic [DATA_W-1:0] wdataMW,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              lsu_stall,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_err;

  logic              w_req;
  logic              w_we;
  logic              w_ok;
  logic              w_capture;
  logic              w_complete;
  logic              w_timeout;
  logic              w_stall;
  logic              w_misalign;
  logic [2:0]        w_ld_f3;
  logic [1:0]        w_ld_lo;

  logic              w_st_ok;
  logic [3:0]        w_st_wstrb;
  logic [DATA_W-1:0] w_st_wdata;
  logic [DATA_W-1:0] w_st_rdata;
  logic              w_ld_ok;
  logic [3:0]        w_ld_wstrb;
  logic [DATA_W-1:0] w_ld_wdata;
  logic [DATA_W-1:0] w_ld_rdata;

  assign w_req = rd_enMW | wr_enMW;
  assign w_we  = wr_enMW;

  // The load formatter checks the incoming load while IDLE; once the access
  // is in flight it extracts mem_rdata using the captured size and offset.
  assign w_ld_f3 = (r_state == IDLE) ? funct3MW     : r_funct3;
  assign w_ld_lo = (r_state == IDLE) ? addrMW[1:0]  : r_addr[1:0];

  lsu_fmt u_fmt_st (
    .i_is_store (1'b1),
    .i_funct3   (funct3MW),
    .i_addr_lo  (addrMW[1:0]),
    .i_wdata    (wdataMW),
    .i_rdata    (mem_rdata),
    .o_ok       (w_st_ok),
    .o_wstrb    (w_st_wstrb),
    .o_wdata    (w_st_wdata),
    .o_rdata    (w_st_rdata)
  );

  lsu_fmt u_fmt_ld (
    .i_is_store (1'b0),
    .i_funct3   (w_ld_f3),
    .i_addr_lo  (w_ld_lo),
    .i_wdata    (wdataMW),
    .i_rdata    (mem_rdata),
    .o_ok       (w_ld_ok),
    .o_wstrb    (w_ld_wstrb),
    .o_wdata    (w_ld_wdata),
    .o_rdata    (w_ld_rdata)
  );

  assign w_ok = w_we ? w_st_ok : w_ld_ok;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;
    w_misalign  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_ok) begin
            w_stall     = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_misalign  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = REQ;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, wait counter, load result and bus-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_wstrb   <= 4'b0000;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr   <= addrMW;
        r_we     <= w_we;
        r_funct3 <= funct3MW;
        r_wstrb  <= w_we ? w_st_wstrb : w_ld_wstrb;
        r_wdata  <= w_we ? w_st_wdata : w_ld_wdata;
      end else begin
        r_addr   <= r_addr;
      end

      if (w_complete) begin
        r_rdata <= r_we ? w_st_rdata : w_ld_rdata;
      end else if (w_timeout) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= r_rdata;
      end

      // Set on the timeout edge so the flag is high exactly for the DONE cycle.
      r_bus_err <= w_timeout;

      if (w_capture || (r_state == DONE)) begin
        r_cnt <= '0;
      end else if ((r_state == REQ) && !w_complete && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign mem_valid    = (r_state == REQ);
  assign mem_we       = r_we;
  assign mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata    = r_wdata;
  assign mem_wstrb    = r_wstrb;
  assign rdata_out    = r_rdata;
  assign bus_err      = r_bus_err;
  // Qualified with rst so the combinational IDLE terms stay low during reset.
  assign lsu_stall    = w_stall & rst;
  assign misalign_err = w_misalign & rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        rd_enMW;
  logic        wr_enMW;
  logic [2:0]  funct3MW;
  logic [31:0] addrMW;
  logic [31:0] wdataMW;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] rdata_out;
  logic        lsu_stall;
  logic        misalign_err;
  logic        bus_err;

  lsu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rd_enMW      (rd_enMW),
    .wr_enMW      (wr_enMW),
    .funct3MW     (funct3MW),
    .addrMW       (addrMW),
    .wdataMW      (wdataMW),
    .mem_valid    (mem_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .rdata_out    (rdata_out),
    .lsu_stall    (lsu_stall),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        berr;
    int          stall;
    int          vcyc;
    int          hs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic is_err, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] rdata, input logic berr,
                              input int stall, input int vcyc, input int hs);
    exp_t e;
    e.is_err = is_err; e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    e.rdata = rdata; e.berr = berr; e.stall = stall; e.vcyc = vcyc; e.hs = hs;
    return e;
  endfunction

  // Monitor: samples on the falling edge and checks against the scoreboard.
  int   stall_cnt = 0;
  int   vcnt      = 0;
  int   hs_cnt    = 0;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      stall_cnt  = 0;
      vcnt       = 0;
      hs_cnt     = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (lsu_stall) stall_cnt++;
      if (mem_valid) begin
        vcnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_mem_valid", {31'd0, mem_valid}, 32'd0);
        end else begin
          chk("valid_on_bad_access", {31'd0, exp_q[0].is_err}, 32'd0);
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
          if (exp_q[0].we) begin
            chk("mem_wdata", mem_wdata, exp_q[0].wdata);
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_q[0].wstrb});
          end else begin
            chk("mem_wstrb_read", {28'd0, mem_wstrb}, 32'd0);
          end
        end
        if (mem_ready) hs_cnt++;
      end
      if (misalign_err) begin
        if (exp_q.size() == 0) begin
          chk("spurious_misalign", {31'd0, misalign_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("misalign_expected", {31'd0, e.is_err}, 32'd1);
          chk("stall_on_misalign", {31'd0, lsu_stall}, 32'd0);
        end
      end
      if (prev_stall && !lsu_stall) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", {31'd0, prev_stall}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_not_error", {31'd0, e.is_err}, 32'd0);
          chk("rdata_out", rdata_out, e.rdata);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          chk("valid_cycles", 32'(vcnt), 32'(e.vcyc));
          chk("handshakes", 32'(hs_cnt), 32'(e.hs));
        end
        stall_cnt = 0;
        vcnt      = 0;
        hs_cnt    = 0;
      end else if (bus_err) begin
        chk("bus_err_outside_done", {31'd0, bus_err}, 32'd0);
      end
      prev_stall = lsu_stall;
    end
  end

  // Present one instruction in MW and play the memory side.
  // waits = REQ cycles without mem_ready; never_rdy lets the access time out.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input bit never_rdy,
                       input logic [31:0] rdat, input exp_t e);
    exp_q.push_back(e);
    rd_enMW   = rd;
    wr_enMW   = wr;
    funct3MW  = f3;
    addrMW    = addr;
    wdataMW   = wd;
    mem_ready = 1'b0;
    mem_rdata = rdat;
    @(posedge clk); #1;
    if (e.is_err) begin
      rd_enMW = 1'b0;
      wr_enMW = 1'b0;
    end else begin
      for (int i = 0; i < waits; i++) begin
        @(posedge clk); #1;
      end
      if (!never_rdy) begin
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
      // DONE cycle: instruction still in MW, leaves on this edge.
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    rd_enMW = 1'b0;
    wr_enMW = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    rd_enMW   = 1'b1;
    wr_enMW   = 1'b0;
    funct3MW  = F3_W;
    addrMW    = 32'h0000_0000;
    wdataMW   = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    #3;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_lsu_stall", {31'd0, lsu_stall}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_rdata_out", rdata_out, 32'd0);
    chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    rd_enMW = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // SW, immediate ready
    issue(1'b0, 1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 0, 1'b0, 32'd0,
          mk(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 2, 1, 1));
    idle(1);
    // LB / LBU at byte 3, three waits
    issue(1'b1, 1'b0, F3_B, 32'h103, 32'd0, 3, 1'b0, 32'h8012_3456,
          mk(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000, 32'hFFFF_FF80, 1'b0, 5, 4, 1));
    idle(1);
    issue(1'b1, 1'b0, F3_BU, 32'h103, 32'd0, 3, 1'b0, 32'h8012_3456,
          mk(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000, 32'h0000_0080, 1'b0, 5, 4, 1));
    idle(1);
    // SH upper half, SB lane 1
    issue(1'b0, 1'b1, F3_H, 32'h202, 32'h0000_1234, 0, 1'b0, 32'd0,
          mk(1'b0, 1'b1, 32'h200, 32'h1234_1234, 4'b1100, 32'd0, 1'b0, 2, 1, 1));
    idle(1);
    issue(1'b0, 1'b1, F3_B, 32'h101, 32'h0000_00AB, 1, 1'b0, 32'd0,
          mk(1'b0, 1'b1, 32'h100, 32'hABAB_ABAB, 4'b0010, 32'd0, 1'b0, 3, 2, 1));
    idle(1);
    // Misaligned / illegal
    issue(1'b1, 1'b0, F3_H, 32'h201, 32'd0, 0, 1'b0, 32'd0,
          mk(1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0, 0, 0, 0));
    idle(1);
    issue(1'b1, 1'b0, 3'b011, 32'h200, 32'd0, 0, 1'b0, 32'd0,
          mk(1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0, 0, 0, 0));
    idle(1);
    issue(1'b0, 1'b1, F3_BU, 32'h200, 32'd0, 0, 1'b0, 32'd0,
          mk(1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0, 0, 0, 0));
    idle(1);
    // Signed/unsigned halfword from upper lane
    issue(1'b1, 1'b0, F3_H, 32'h602, 32'd0, 0, 1'b0, 32'h9ABC_0000,
          mk(1'b0, 1'b0, 32'h600, 32'd0, 4'b0000, 32'hFFFF_9ABC, 1'b0, 2, 1, 1));
    idle(1);
    issue(1'b1, 1'b0, F3_HU, 32'h602, 32'd0, 0, 1'b0, 32'h9ABC_0000,
          mk(1'b0, 1'b0, 32'h600, 32'd0, 4'b0000, 32'h0000_9ABC, 1'b0, 2, 1, 1));
    idle(1);
    // LW leaving nonzero rdata_out, then LW that times out
    issue(1'b1, 1'b0, F3_W, 32'h400, 32'd0, 0, 1'b0, 32'hCAFE_F00D,
          mk(1'b0, 1'b0, 32'h400, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b0, 2, 1, 1));
    idle(1);
    issue(1'b1, 1'b0, F3_W, 32'h300, 32'd0, 16, 1'b1, 32'h5555_5555,
          mk(1'b0, 1'b0, 32'h300, 32'd0, 4'b0000, 32'd0, 1'b1, 17, 16, 0));
    idle(1);
    // Back-to-back LW then SW
    issue(1'b1, 1'b0, F3_W, 32'h500, 32'd0, 0, 1'b0, 32'h1122_3344,
          mk(1'b0, 1'b0, 32'h500, 32'd0, 4'b0000, 32'h1122_3344, 1'b0, 2, 1, 1));
    issue(1'b0, 1'b1, F3_W, 32'h504, 32'hA5A5_A5A5, 0, 1'b0, 32'd0,
          mk(1'b0, 1'b1, 32'h504, 32'hA5A5_A5A5, 4'b1111, 32'd0, 1'b0, 2, 1, 1));
    idle(2);

    // Reset during the 2nd REQ cycle
    exp_q.push_back(mk(1'b0, 1'b0, 32'h700, 32'd0, 4'b0000, 32'd0, 1'b0, 0, 0, 0));
    rd_enMW  = 1'b1;
    funct3MW = F3_W;
    addrMW   = 32'h700;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
    #1;
    rst     = 1'b0;
    rd_enMW = 1'b0;
    #1;
    chk("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("async_rst_lsu_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    chk("post_rst_idle_valid", {31'd0, mem_valid}, 32'd0);
    issue(1'b1, 1'b0, F3_W, 32'h800, 32'd0, 1, 1'b0, 32'h0BAD_CAFE,
          mk(1'b0, 1'b0, 32'h800, 32'd0, 4'b0000, 32'h0BAD_CAFE, 1'b0, 3, 2, 1));
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
